// File: rtl/hfrv_mem_arbiter_if.sv
// hfrv_mem_arbiter_if: one requester port (req/addr/we/wdata in, gnt/rvalid/rdata back); master = requester, slave = arbiter
interface hfrv_mem_arbiter_if #(parameter int ADDR_W = 32, parameter int DATA_W = 32);
  logic              req;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W/8-1:0] we;
  logic [DATA_W-1:0] wdata;
  logic              gnt;
  logic              rvalid;
  logic [DATA_W-1:0] rdata;
  modport master (output req, addr, we, wdata, input gnt, rvalid, rdata);
  modport slave  (input req, addr, we, wdata, output gnt, rvalid, rdata);
endinterface

// File: rtl/hfrv_mem_arbiter.sv
// hfrv_mem_arbiter: two-port SRAM arbiter, port 0 priority with forced port-1 grant after MAX_WAIT blocked cycles; ports clk, reset, m0/m1 (slave), mem_en/addr/we/wdata out, mem_rdata in
module hfrv_mem_arbiter #(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int MEM_LAT  = 1,
  parameter int MAX_WAIT = 8
) (
  input  logic                clk,
  input  logic                reset,
  hfrv_mem_arbiter_if.slave   m0,
  hfrv_mem_arbiter_if.slave   m1,
  output logic                mem_en,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W/8-1:0] mem_we,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic [DATA_W-1:0]   mem_rdata
);
  typedef enum logic {PRI0, FORCE1} state_t;
  state_t             state;
  logic [7:0]         wait_cnt, wait_nxt;
  logic [MEM_LAT-1:0] tag_v, tag_p;
  logic               rd_issue, tail0, tail1;
  always_comb begin
    m0.gnt    = !reset && m0.req && state == PRI0;
    m1.gnt    = !reset && m1.req && (state == FORCE1 || !m0.req);
    mem_en    = m0.gnt || m1.gnt;
    mem_addr  = m0.gnt ? m0.addr  : m1.gnt ? m1.addr  : '0;
    mem_we    = m0.gnt ? m0.we    : m1.gnt ? m1.we    : '0;
    mem_wdata = m0.gnt ? m0.wdata : m1.gnt ? m1.wdata : '0;
    rd_issue  = mem_en && mem_we == '0;
    wait_nxt  = (!m1.req || m1.gnt) ? 8'd0 : (wait_cnt == 8'(MAX_WAIT)) ? wait_cnt : wait_cnt + 8'd1;
    // the oldest tag sits in the top bit and lines up with mem_rdata
    tail0     = !reset && tag_v[MEM_LAT-1] && !tag_p[MEM_LAT-1];
    tail1     = !reset && tag_v[MEM_LAT-1] && tag_p[MEM_LAT-1];
    m0.rvalid = tail0;
    m1.rvalid = tail1;
    m0.rdata  = tail0 ? mem_rdata : '0;
    m1.rdata  = tail1 ? mem_rdata : '0;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= PRI0;
      wait_cnt <= 8'd0;
      tag_v    <= '0;
      tag_p    <= '0;
    end else begin
      wait_cnt <= wait_nxt;
      state    <= (state == PRI0) ? ((wait_nxt == 8'(MAX_WAIT)) ? FORCE1 : PRI0)
                                  : ((m1.gnt || !m1.req) ? PRI0 : FORCE1);
      tag_v    <= (tag_v << 1) | MEM_LAT'(rd_issue);
      tag_p    <= (tag_p << 1) | MEM_LAT'(m1.gnt);
    end
  end
endmodule

// File: tb/tb_hfrv_mem_arbiter.sv
// tb_hfrv_mem_arbiter: directed vector table plus random traffic against a queue-based reference model
module tb_hfrv_mem_arbiter;
  localparam int LAT  = 2;
  localparam int MAXW = 4;
  logic clk = 0, reset;
  logic mem_en;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0] mem_we;
  hfrv_mem_arbiter_if #(32, 32) m0_if();
  hfrv_mem_arbiter_if #(32, 32) m1_if();
  hfrv_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(LAT), .MAX_WAIT(MAXW)) dut (
    .clk(clk), .reset(reset), .m0(m0_if), .m1(m1_if),
    .mem_en(mem_en), .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata));
  always #5 clk = ~clk;

  function automatic logic [31:0] f(input logic [31:0] a);
    return (a == 32'h100) ? 32'hDEADBEEF : a * 32'h9E3779B1 + 32'h5;
  endfunction
  function automatic logic [31:0] wd(input logic [31:0] a);
    return a ^ 32'h12345478;
  endfunction

  // memory environment: returns f(addr) LAT cycles after a read strobe, noise otherwise
  logic [LAT-1:0] env_v;
  logic [31:0] env_a [LAT];
  logic [31:0] junk;
  always @(posedge clk) begin
    env_v <= {env_v[LAT-2:0], mem_en && mem_we == 4'h0};
    env_a[0] <= mem_addr;
    for (int i = 1; i < LAT; i++) env_a[i] <= env_a[i-1];
    junk <= $urandom;
  end
  assign mem_rdata = env_v[LAT-1] ? f(env_a[LAT-1]) : junk;

  typedef struct {
    bit rst, r0, r1;
    logic [3:0] we0, we1;
    logic [31:0] a0, a1;
    bit g0, g1, v0, v1;
  } vec_t;
  typedef struct { int due; bit p; logic [31:0] a; } rd_t;
  vec_t tab[$];
  rd_t q[$];
  int pass = 0, total = 0, cyc = 0, m_wait = 0;
  bit m_force = 0;

  function automatic vec_t mk(bit rst, bit r0, logic [3:0] we0, logic [31:0] a0,
                              bit r1, logic [3:0] we1, logic [31:0] a1, bit g0, bit g1, bit v0, bit v1);
    vec_t v;
    v.rst = rst; v.r0 = r0; v.we0 = we0; v.a0 = a0; v.r1 = r1; v.we1 = we1; v.a1 = a1;
    v.g0 = g0; v.g1 = g1; v.v0 = v0; v.v1 = v1;
    return v;
  endfunction

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) pass++;
    else $display("FAIL %s cyc=%0d got=%h exp=%h", n, cyc, act, exp);
  endtask

  task automatic step(input vec_t v, input bit tabchk);
    bit e_g0, e_g1, due, e_v0, e_v1;
    logic [31:0] e_addr, e_wd, e_rd;
    logic [3:0] e_we;
    @(posedge clk); #1;
    reset = v.rst;
    m0_if.req = v.r0; m0_if.addr = v.a0; m0_if.we = v.we0; m0_if.wdata = wd(v.a0);
    m1_if.req = v.r1; m1_if.addr = v.a1; m1_if.we = v.we1; m1_if.wdata = wd(v.a1);
    @(negedge clk);
    e_g0 = !v.rst && v.r0 && !m_force;
    e_g1 = !v.rst && v.r1 && (m_force || !v.r0);
    e_addr = e_g0 ? v.a0 : e_g1 ? v.a1 : 32'h0;
    e_we = e_g0 ? v.we0 : e_g1 ? v.we1 : 4'h0;
    e_wd = (e_g0 || e_g1) ? wd(e_addr) : 32'h0;
    due = q.size() > 0 && q[0].due == cyc;
    e_v0 = !v.rst && due && !q[0].p;
    e_v1 = !v.rst && due && q[0].p;
    e_rd = due ? f(q[0].a) : 32'h0;
    chk("m0_gnt", 32'(m0_if.gnt), 32'(e_g0));
    chk("m1_gnt", 32'(m1_if.gnt), 32'(e_g1));
    chk("mem_en", 32'(mem_en), 32'(e_g0 || e_g1));
    chk("mem_addr", mem_addr, e_addr);
    chk("mem_we", 32'(mem_we), 32'(e_we));
    chk("mem_wdata", mem_wdata, e_wd);
    chk("m0_rvalid", 32'(m0_if.rvalid), 32'(e_v0));
    chk("m1_rvalid", 32'(m1_if.rvalid), 32'(e_v1));
    chk("m0_rdata", m0_if.rdata, e_v0 ? e_rd : 32'h0);
    chk("m1_rdata", m1_if.rdata, e_v1 ? e_rd : 32'h0);
    if (tabchk) begin
      chk("tab_g0", 32'(m0_if.gnt), 32'(v.g0));
      chk("tab_g1", 32'(m1_if.gnt), 32'(v.g1));
      chk("tab_v0", 32'(m0_if.rvalid), 32'(v.v0));
      chk("tab_v1", 32'(m1_if.rvalid), 32'(v.v1));
    end
    if (due) void'(q.pop_front());
    if (v.rst) begin
      q.delete(); m_wait = 0; m_force = 0;
    end else begin
      if ((e_g0 || e_g1) && e_we == 4'h0) q.push_back('{cyc + LAT, e_g1, e_addr});
      m_wait = (!v.r1 || e_g1) ? 0 : (m_wait + 1 > MAXW ? MAXW : m_wait + 1);
      m_force = m_force ? (v.r1 && !e_g1) : (m_wait == MAXW);
    end
    cyc++;
  endtask

  initial begin
    vec_t v;
    reset = 1;
    m0_if.req = 0; m0_if.addr = 0; m0_if.we = 0; m0_if.wdata = 0;
    m1_if.req = 0; m1_if.addr = 0; m1_if.we = 0; m1_if.wdata = 0;
    // reset, then lone m0 read returning DEADBEEF LAT cycles later
    tab.push_back(mk(1, 1, 0, 32'h100, 1, 0, 32'h4,  0, 0, 0, 0));
    tab.push_back(mk(0, 1, 0, 32'h100, 0, 0, 32'h0,  1, 0, 0, 0));
    tab.push_back(mk(0, 0, 0, 32'h0,   0, 0, 32'h0,  0, 0, 0, 0));
    tab.push_back(mk(0, 0, 0, 32'h0,   0, 0, 32'h0,  0, 0, 1, 0));
    // m1 write, no rvalid anywhere
    tab.push_back(mk(0, 0, 0, 32'h0,   1, 4'hF, 32'h200, 0, 1, 0, 0));
    tab.push_back(mk(0, 0, 0, 32'h0,   0, 0, 32'h0,  0, 0, 0, 0));
    tab.push_back(mk(0, 0, 0, 32'h0,   0, 0, 32'h0,  0, 0, 0, 0));
    // alternating reads, returned in order to the issuing port
    tab.push_back(mk(0, 1, 0, 32'h0,   0, 0, 32'h0,  1, 0, 0, 0));
    tab.push_back(mk(0, 0, 0, 32'h0,   1, 0, 32'h4,  0, 1, 0, 0));
    tab.push_back(mk(0, 1, 0, 32'h8,   0, 0, 32'h0,  1, 0, 1, 0));
    tab.push_back(mk(0, 0, 0, 32'h0,   0, 0, 32'h0,  0, 0, 0, 1));
    tab.push_back(mk(0, 0, 0, 32'h0,   0, 0, 32'h0,  0, 0, 1, 0));
    tab.push_back(mk(0, 0, 0, 32'h0,   0, 0, 32'h0,  0, 0, 0, 0));
    // both held: m0 x4, forced m1, repeat with period 5
    for (int i = 0; i < 10; i++)
      tab.push_back(mk(0, 1, 4'hF, 32'h10, 1, 4'hF, 32'h20, (i % 5) != 4, (i % 5) == 4, 0, 0));
    // m1 blocked 3 cycles then drops: the full MAX_WAIT count starts again
    for (int i = 0; i < 3; i++) tab.push_back(mk(0, 1, 4'hF, 32'h30, 1, 0, 32'h300, 1, 0, 0, 0));
    tab.push_back(mk(0, 1, 4'hF, 32'h30, 0, 0, 32'h300, 1, 0, 0, 0));
    for (int i = 0; i < 4; i++) tab.push_back(mk(0, 1, 4'hF, 32'h30, 1, 0, 32'h300, 1, 0, 0, 0));
    tab.push_back(mk(0, 1, 4'hF, 32'h30, 1, 0, 32'h300, 0, 1, 0, 0));
    tab.push_back(mk(0, 0, 0, 32'h0,   0, 0, 32'h0,  0, 0, 0, 0));
    tab.push_back(mk(0, 0, 0, 32'h0,   0, 0, 32'h0,  0, 0, 0, 1));
    // read then reset: the read never returns, counter restarts from zero
    tab.push_back(mk(0, 1, 0, 32'h40,  0, 0, 32'h0,  1, 0, 0, 0));
    tab.push_back(mk(1, 1, 0, 32'h40,  1, 0, 32'h44, 0, 0, 0, 0));
    tab.push_back(mk(0, 0, 0, 32'h0,   0, 0, 32'h0,  0, 0, 0, 0));
    tab.push_back(mk(0, 0, 0, 32'h0,   0, 0, 32'h0,  0, 0, 0, 0));
    for (int i = 0; i < 4; i++) tab.push_back(mk(0, 1, 4'hF, 32'h50, 1, 4'hF, 32'h54, 1, 0, 0, 0));
    tab.push_back(mk(0, 1, 4'hF, 32'h50, 1, 4'hF, 32'h54, 0, 1, 0, 0));
    tab.push_back(mk(0, 0, 0, 32'h0,   0, 0, 32'h0,  0, 0, 0, 0));
    foreach (tab[i]) step(tab[i], 1);
    for (int i = 0; i < 400; i++) begin
      v = mk($urandom_range(0, 39) == 0, $urandom_range(0, 2) != 0,
             $urandom_range(0, 1) ? 4'($urandom) : 4'h0, $urandom,
             $urandom_range(0, 2) != 0,
             $urandom_range(0, 1) ? 4'($urandom) : 4'h0, $urandom, 0, 0, 0, 0);
      step(v, 0);
    end
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end
endmodule
